// File: rtl/sd_req_arbiter_if.sv
// sd_req_arbiter_if: hps_io-side sd strobe/lba/ack bundle
interface sd_req_arbiter_if #(
   parameter int CHANNELS = 3,
   parameter int LBA_W = 32
);
   logic [CHANNELS-1:0] sd_rd;
   logic [CHANNELS-1:0] sd_wr;
   logic [LBA_W-1:0] sd_lba;
   logic sd_ack;
   modport master (output sd_rd, sd_wr, sd_lba, input sd_ack);
   modport slave (input sd_rd, sd_wr, sd_lba, output sd_ack);
endinterface

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: round-robin arbiter turning per-channel rd/wr request edges into one-hot hps_io strobes
module sd_req_arbiter #(
   parameter int CHANNELS = 3,
   parameter int SYNC_STAGES = 3,
   parameter int LBA_W = 32,
   parameter int TIMEOUT = 0,
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
)(
   input logic clk_100m,
   input logic reset_n,
   input logic [CHANNELS-1:0] req_rd,
   input logic [CHANNELS-1:0] req_wr,
   input logic [CHANNELS*LBA_W-1:0] req_lba,
   sd_req_arbiter_if.master sd,
   output logic [CHANNELS-1:0] done,
   output logic [CHANNELS-1:0] err,
   output logic busy,
   output logic [CW-1:0] active_ch
);
   typedef enum logic [1:0] {IDLE, ISSUE, ACK_LO} state_t;
   state_t state;
   logic [CHANNELS-1:0] sync_rd [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_wr [SYNC_STAGES];
   logic [CHANNELS-1:0] hist_rd, hist_wr, rise_rd, rise_wr, pend_rd, pend_wr, clr_rd, clr_wr;
   logic [CHANNELS-1:0] gnt_oh, act_oh;
   logic [CW-1:0] ptr, gnt_ch;
   logic gnt_any, gnt_wr;
   logic [31:0] cnt;

   assign rise_rd = sync_rd[SYNC_STAGES-1] & ~hist_rd;
   assign rise_wr = sync_wr[SYNC_STAGES-1] & ~hist_wr;
   assign gnt_oh = CHANNELS'(1) << gnt_ch;
   assign act_oh = CHANNELS'(1) << active_ch;
   assign busy = state != IDLE;

   // synchronise the async request levels, then keep one history flop for edge detection
   always_ff @(posedge clk_100m) begin
      if (!reset_n) begin
         sync_rd <= '{default: '0};
         sync_wr <= '{default: '0};
         hist_rd <= '0;
         hist_wr <= '0;
      end else begin
         sync_rd[0] <= req_rd;
         sync_wr[0] <= req_wr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_rd[i] <= sync_rd[i-1];
            sync_wr[i] <= sync_wr[i-1];
         end
         hist_rd <= sync_rd[SYNC_STAGES-1];
         hist_wr <= sync_wr[SYNC_STAGES-1];
      end
   end

   // pending bits: a fresh rise wins over the grant clear so a re-request on the serviced channel survives
   always_ff @(posedge clk_100m) begin
      if (!reset_n) begin
         pend_rd <= '0;
         pend_wr <= '0;
      end else begin
         pend_rd <= (pend_rd & ~clr_rd) | rise_rd;
         pend_wr <= (pend_wr & ~clr_wr) | rise_wr;
      end
   end

   // round-robin search starting at ptr; the lowest offset wins, and write beats read within a channel
   always_comb begin
      logic [CW-1:0] c;
      c = '0;
      gnt_any = 1'b0;
      gnt_ch = '0;
      gnt_wr = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         c = CW'((int'(ptr) + i) % CHANNELS);
         if (pend_rd[c] | pend_wr[c]) begin
            gnt_any = state == IDLE;
            gnt_ch = c;
            gnt_wr = pend_wr[c];
         end
      end
      clr_wr = gnt_any && gnt_wr ? gnt_oh : '0;
      clr_rd = gnt_any && !gnt_wr ? gnt_oh : '0;
   end

   // grant, hold the strobe until ack or timeout, then wait for ack low and pulse done
   always_ff @(posedge clk_100m) begin
      if (!reset_n) begin
         state <= IDLE;
         sd.sd_rd <= '0;
         sd.sd_wr <= '0;
         sd.sd_lba <= '0;
         done <= '0;
         err <= '0;
         active_ch <= '0;
         ptr <= '0;
         cnt <= '0;
      end else begin
         done <= '0;
         err <= '0;
         case (state)
            IDLE: if (gnt_any) begin
               sd.sd_rd <= gnt_wr ? '0 : gnt_oh;
               sd.sd_wr <= gnt_wr ? gnt_oh : '0;
               sd.sd_lba <= req_lba[gnt_ch*LBA_W +: LBA_W];
               active_ch <= gnt_ch;
               ptr <= gnt_ch == CW'(CHANNELS - 1) ? '0 : gnt_ch + 1'b1;
               cnt <= '0;
               state <= ISSUE;
            end
            ISSUE: if (sd.sd_ack) begin
               sd.sd_rd <= '0;
               sd.sd_wr <= '0;
               state <= ACK_LO;
            end else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
               sd.sd_rd <= '0;
               sd.sd_wr <= '0;
               err <= act_oh;
               state <= IDLE;
            end else begin
               cnt <= cnt + 1;
            end
            ACK_LO: if (!sd.sd_ack) begin
               done <= act_oh;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sd_req_arbiter.sv
// tb_sd_req_arbiter: randomized scoreboard bench for the round-robin sd request arbiter
module tb_sd_req_arbiter;
   localparam int CH = 3;
   localparam int LW = 32;
   localparam int TO = 16;

   typedef struct {
      int ch;
      bit wr;
      logic [LW-1:0] lba;
      bit to;
   } exp_t;

   logic clk_100m = 1'b0;
   logic reset_n = 1'b0;
   logic [CH-1:0] req_rd = '0;
   logic [CH-1:0] req_wr = '0;
   logic [LW-1:0] lba_v [CH];
   logic [CH*LW-1:0] req_lba;
   logic [CH-1:0] done, err;
   logic busy;
   logic [1:0] active_ch;
   logic rsp_ack = 1'b0;
   logic idle_ack = 1'b0;

   exp_t q[$];
   exp_t cur;
   bit cur_v = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   int m_ptr = 0;
   bit rsp_en = 1'b1;
   bit rsp_fix = 1'b0;
   bit rsp_busy = 1'b0;
   int rsp_dly = 0;
   int rsp_len = 1;

   sd_req_arbiter_if #(.CHANNELS(CH), .LBA_W(LW)) sd ();

   assign sd.sd_ack = rsp_ack | idle_ack;
   assign req_lba = {lba_v[2], lba_v[1], lba_v[0]};

   sd_req_arbiter #(.CHANNELS(CH), .SYNC_STAGES(3), .LBA_W(LW), .TIMEOUT(TO)) dut (
      .clk_100m(clk_100m),
      .reset_n(reset_n),
      .req_rd(req_rd),
      .req_wr(req_wr),
      .req_lba(req_lba),
      .sd(sd),
      .done(done),
      .err(err),
      .busy(busy),
      .active_ch(active_ch)
   );

   always #5 clk_100m = ~clk_100m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // reference: serve a snapshot of pending requests by round-robin, write before read
   task automatic model(input bit [CH-1:0] prd, input bit [CH-1:0] pwr, input bit to);
      exp_t e;
      int c;
      while ((prd | pwr) != 0) begin
         c = m_ptr;
         while (!(prd[c] | pwr[c])) c = (c + 1) % CH;
         e.ch = c;
         e.wr = pwr[c];
         e.lba = lba_v[c];
         e.to = to;
         if (pwr[c]) pwr[c] = 1'b0;
         else prd[c] = 1'b0;
         q.push_back(e);
         m_ptr = (c + 1) % CH;
      end
   endtask

   task automatic issue(input bit [CH-1:0] rd, input bit [CH-1:0] wr, input bit to);
      @(negedge clk_100m);
      for (int c = 0; c < CH; c++) if (rd[c] | wr[c]) lba_v[c] = $urandom;
      model(rd, wr, to);
      req_rd = rd;
      req_wr = wr;
      repeat ($urandom_range(1, 3)) @(negedge clk_100m);
      req_rd = '0;
      req_wr = '0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(posedge clk_100m);
         #2;
         n++;
      end while (n < 3000 && !(q.size() == 0 && !cur_v && !busy && !sd.sd_ack && !rsp_busy));
      chk({name, " reaches idle"}, 64'(n < 3000), 1);
   endtask

   task automatic wait_strobe(input bit hi, input string name);
      int n = 0;
      while (n < 100 && (((sd.sd_rd | sd.sd_wr) != 0) != hi)) begin
         @(posedge clk_100m);
         #1;
         n++;
      end
      chk(name, 64'(n < 100), 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " sd_rd"}, sd.sd_rd, 0);
      chk({tag, " sd_wr"}, sd.sd_wr, 0);
      chk({tag, " sd_lba"}, sd.sd_lba, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " err"}, err, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " active_ch"}, active_ch, 0);
   endtask

   // ack responder: waits a delay after seeing a strobe, then holds ack for a while
   initial begin
      forever begin
         @(negedge clk_100m);
         if (rsp_en && (sd.sd_rd | sd.sd_wr) != 0) begin
            rsp_busy = 1'b1;
            repeat (rsp_fix ? rsp_dly : $urandom_range(0, 6)) @(negedge clk_100m);
            rsp_ack = 1'b1;
            repeat (rsp_fix ? rsp_len : $urandom_range(1, 3)) @(negedge clk_100m);
            rsp_ack = 1'b0;
            rsp_busy = 1'b0;
         end
      end
   end

   // monitor: pops an expectation at each new strobe and tracks it to its done or err pulse
   initial begin
      logic [CH-1:0] s, ps, oh;
      int h;
      ps = '0;
      h = 0;
      oh = '0;
      forever begin
         @(posedge clk_100m);
         #1;
         if (!reset_n) begin
            cur_v = 1'b0;
            ps = '0;
            continue;
         end
         s = sd.sd_rd | sd.sd_wr;
         if (s != 0) chk("strobe one-hot", 64'($onehot({sd.sd_rd, sd.sd_wr})), 1);
         if (ps == 0 && s != 0) begin
            if (q.size() == 0) chk("unexpected strobe", s, 0);
            else begin
               cur = q.pop_front();
               cur_v = 1'b1;
               h = 0;
               oh = CH'(1) << cur.ch;
               chk("grant sd_wr", sd.sd_wr, cur.wr ? oh : '0);
               chk("grant sd_rd", sd.sd_rd, cur.wr ? '0 : oh);
               chk("grant sd_lba", sd.sd_lba, cur.lba);
               chk("grant active_ch", active_ch, cur.ch);
               chk("grant busy", busy, 1);
            end
         end
         if (s != 0) begin
            h++;
            if (ps != 0 && sd.sd_ack) chk("strobe held after ack", s, 0);
         end
         if (ps != 0 && s == 0) begin
            if (cur_v && cur.to) begin
               chk("timeout strobe cycles", h, TO);
               chk("timeout err", err, oh);
               chk("timeout done", done, 0);
               chk("timeout busy", busy, 0);
               cur_v = 1'b0;
            end else chk("strobe dropped by ack", sd.sd_ack, 1);
         end else if ((done | err) != 0) begin
            if (cur_v && !cur.to && s == 0) begin
               chk("done pulse", done, oh);
               chk("err on done", err, 0);
               chk("ack low at done", sd.sd_ack, 0);
               cur_v = 1'b0;
            end else chk("unexpected done/err", {err, done}, 0);
         end
         ps = s;
      end
   end

   initial begin
      bit [CH-1:0] rd, wr;
      int n;
      for (int c = 0; c < CH; c++) lba_v[c] = '0;
      repeat (3) @(negedge clk_100m);
      @(posedge clk_100m);
      #1;
      chk_zero("reset");
      @(negedge clk_100m);
      reset_n = 1'b1;

      rsp_fix = 1'b1;
      rsp_dly = 3;
      rsp_len = 2;
      @(negedge clk_100m);
      lba_v[1] = 32'h1234;
      model(3'b010, 3'b000, 1'b0);
      req_rd = 3'b010;
      n = 0;
      do begin
         @(posedge clk_100m);
         #1;
         n++;
      end while (n < 20 && sd.sd_rd == 0);
      chk("rise to strobe latency", n, 5);
      @(negedge clk_100m);
      req_rd = '0;
      wait_idle("single read");

      rsp_fix = 1'b0;
      issue(3'b001, 3'b001, 1'b0);
      wait_idle("rd+wr same channel");

      rsp_fix = 1'b1;
      rsp_dly = 2;
      rsp_len = 15;
      issue(3'b001, 3'b000, 1'b0);
      wait_strobe(1'b1, "merge first strobe");
      @(negedge clk_100m);
      lba_v[2] = $urandom;
      model(3'b100, 3'b000, 1'b0);
      req_rd[2] = 1'b1;
      repeat (2) @(negedge clk_100m);
      req_rd[2] = 1'b0;
      repeat (2) @(negedge clk_100m);
      req_rd[2] = 1'b1;
      repeat (2) @(negedge clk_100m);
      req_rd[2] = 1'b0;
      wait_idle("merge");

      rsp_en = 1'b0;
      issue(3'b000, 3'b100, 1'b1);
      wait_idle("timeout");
      rsp_en = 1'b1;
      rsp_fix = 1'b0;
      issue(3'b010, 3'b000, 1'b0);
      wait_idle("after timeout");

      rsp_en = 1'b0;
      @(negedge clk_100m);
      idle_ack = 1'b1;
      repeat (5) @(posedge clk_100m);
      #1;
      chk("ack in idle busy", busy, 0);
      issue(3'b001, 3'b000, 1'b0);
      wait_strobe(1'b1, "early ack strobe");
      repeat (4) @(negedge clk_100m);
      idle_ack = 1'b0;
      rsp_en = 1'b1;
      wait_idle("early ack");

      rsp_fix = 1'b1;
      rsp_dly = 1;
      rsp_len = 20;
      issue(3'b010, 3'b000, 1'b0);
      wait_strobe(1'b1, "reset test strobe");
      @(negedge clk_100m);
      req_rd = 3'b100;
      repeat (2) @(negedge clk_100m);
      req_rd = '0;
      wait_strobe(1'b0, "reset test ack_lo");
      repeat (5) @(negedge clk_100m);
      reset_n = 1'b0;
      @(posedge clk_100m);
      #1;
      chk_zero("mid-transfer reset");
      @(negedge clk_100m);
      reset_n = 1'b1;
      m_ptr = 0;
      wait_idle("after reset");

      rsp_fix = 1'b0;
      issue(3'b111, 3'b000, 1'b0);
      wait_idle("round robin");

      repeat (30) begin
         rd = CH'($urandom);
         wr = CH'($urandom);
         if ((rd | wr) == 0) rd = 3'b001;
         issue(rd, wr, 1'b0);
         wait_idle("random batch");
      end
      chk("unserved expectations", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
